// File: rtl/clk_divider_n_if.sv
// Bundle between a divider and its user: run/divisor controls in, divided clock and status out.
// Latency: none; the interface carries no logic.
// Backpressure: none; all signals are level or single-cycle strobes.
interface clk_divider_n_if #(
    parameter int CNT_W = 8
);
    logic             en_i;
    logic [CNT_W-1:0] div_i;
    logic             div_load_i;
    logic             clk_o;
    logic             tick_o;
    logic [CNT_W-1:0] div_active_o;

    // Controller side: drives run/divisor requests, observes the divided outputs.
    modport master (
        output en_i,
        output div_i,
        output div_load_i,
        input  clk_o,
        input  tick_o,
        input  div_active_o
    );

    // Divider side.
    modport slave (
        input  en_i,
        input  div_i,
        input  div_load_i,
        output clk_o,
        output tick_o,
        output div_active_o
    );
endinterface

// File: rtl/clk_divider_n.sv
// Runtime-programmable integer divider: clk_o = clk_i/N with N in [2, 2^CNT_W-1], tick_o per period.
// Latency: outputs are flops; clk_o/tick_o rise one clk_i cycle after en_i is first sampled high.
// Backpressure: none; a divisor load is held pending and applied only at a period boundary or while stopped.
module clk_divider_n #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    clk_divider_n_if.slave        bus
);

    // Period position; always in [0, div_active-1] while running, 0 while stopped.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_pend;
    logic             pend_vld;
    logic             clk_q;
    logic             tick_q;

    logic [CNT_W-1:0] div_clamped;
    logic [CNT_W:0]   half;
    logic             at_last;
    logic             wrap;
    logic             apply;

    // Divisors 0 and 1 are meaningless for a period counter, so they are forced to 2.
    always_comb begin
        div_clamped = bus.div_i;
        if (bus.div_i < CNT_W'(2)) begin
            div_clamped = CNT_W'(2);
        end
    end

    // High-phase length ceil(N/2) is formed one bit wider so N = 2^CNT_W-1 cannot overflow.
    // A pending divisor may only take over at a period boundary or while the divider is parked,
    // which keeps every output period whole.
    always_comb begin
        half    = ({1'b0, div_active} + (CNT_W+1)'(1)) >> 1;
        at_last = (cnt == (div_active - CNT_W'(1)));
        wrap    = bus.en_i && at_last;
        apply   = pend_vld && (wrap || !bus.en_i);
    end

    // Period counter and registered clock/tick outputs; stopping parks everything low at once.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (bus.en_i) begin
            clk_q  <= ({1'b0, cnt} < half);
            tick_q <= (cnt == '0);
            cnt    <= wrap ? '0 : cnt + CNT_W'(1);
        end else begin
            cnt    <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end
    end

    // Pending/active divisor pair. A load coinciding with an apply lands in the slot after the
    // old pending value has moved to active, so the new value waits for the following boundary.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_active <= CNT_W'(DEF_DIV);
            div_pend   <= '0;
            pend_vld   <= 1'b0;
        end else begin
            if (apply) begin
                div_active <= div_pend;
            end
            if (bus.div_load_i) begin
                div_pend <= div_clamped;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    assign bus.clk_o        = clk_q;
    assign bus.tick_o       = tick_q;
    assign bus.div_active_o = div_active;

endmodule

// File: tb/tb_clk_divider_n.sv
module tb_clk_divider_n;

    localparam int CNT_W = 8;

    typedef struct {
        logic             clk;
        logic             tick;
        logic [CNT_W-1:0] div;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    clk_divider_n_if #(.CNT_W(CNT_W)) ifc ();

    clk_divider_n #(.CNT_W(CNT_W), .DEF_DIV(2)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (ifc)
    );

    always #5 clk_i = ~clk_i;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference model state (independent cycle model of the divider).
    int m_cnt  = 0;
    int m_div  = 2;
    int m_pend = 0;
    bit m_pvld = 0;

    // Observed clk_o run-length tracking.
    logic prev_clk = 1'b0;
    int   cur_run  = 0;
    int   last_hi  = 0;
    int   last_lo  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic runs_clear();
        prev_clk = ifc.clk_o;
        cur_run  = 0;
        last_hi  = 0;
        last_lo  = 0;
    endtask

    // One clk_i cycle: drive inputs, predict, let the edge happen, compare.
    task automatic step(input logic rst, input logic en, input int div, input logic ld);
        exp_t e;
        bit   wr;
        @(negedge clk_i);
        rst_ni         = rst;
        ifc.en_i       = en;
        ifc.div_i      = CNT_W'(div);
        ifc.div_load_i = ld;
        if (!rst) begin
            m_cnt = 0; m_div = 2; m_pvld = 0;
            e.clk = 1'b0; e.tick = 1'b0;
        end else begin
            wr = en && (m_cnt == m_div - 1);
            if (en) begin
                e.clk  = (2 * m_cnt < m_div);
                e.tick = (m_cnt == 0);
                m_cnt  = wr ? 0 : m_cnt + 1;
            end else begin
                e.clk = 1'b0; e.tick = 1'b0; m_cnt = 0;
            end
            if (m_pvld && (wr || !en)) begin
                m_div  = m_pend;
                m_pvld = 0;
            end
            if (ld) begin
                m_pend = (div < 2) ? 2 : div;
                m_pvld = 1;
            end
        end
        e.div = CNT_W'(m_div);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("clk_o", int'(ifc.clk_o), int'(e.clk));
            chk("tick_o", int'(ifc.tick_o), int'(e.tick));
            chk("div_active_o", int'(ifc.div_active_o), int'(e.div));
        end
        if (ifc.clk_o === prev_clk) begin
            cur_run++;
        end else begin
            if (prev_clk) last_hi = cur_run; else last_lo = cur_run;
            cur_run = 1;
        end
        prev_clk = ifc.clk_o;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic run_to_cnt(input int c);
        for (int i = 0; i < 600 && m_cnt != c; i++) step(1'b1, 1'b1, 0, 1'b0);
        chk("reach_cnt", m_cnt, c);
    endtask

    initial begin
        ifc.en_i       = 1'b0;
        ifc.div_i      = '0;
        ifc.div_load_i = 1'b0;

        // T1: reset, then run at the default divisor.
        step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("t1_rst_clk", int'(ifc.clk_o), 0);
        chk("t1_rst_tick", int'(ifc.tick_o), 0);
        chk("t1_rst_div", int'(ifc.div_active_o), 2);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("t1_first_clk", int'(ifc.clk_o), 1);
        chk("t1_first_tick", int'(ifc.tick_o), 1);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("t1_second_clk", int'(ifc.clk_o), 0);
        chk("t1_second_tick", int'(ifc.tick_o), 0);
        run(8);

        // T2: load 5 while stopped, then run.
        step(1'b1, 1'b0, 5, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("t2_div", int'(ifc.div_active_o), 5);
        runs_clear();
        run(17);
        chk("t2_hi", last_hi, 3);
        chk("t2_lo", last_lo, 2);

        // T3: N=6 running, load 3 at cnt=2; change lands exactly on the wrap.
        step(1'b1, 1'b0, 6, 1'b1);
        run(7);
        run_to_cnt(2);
        step(1'b1, 1'b1, 3, 1'b1);
        chk("t3_div_after_load", int'(ifc.div_active_o), 6);
        run(2);
        chk("t3_div_before_wrap", int'(ifc.div_active_o), 6);
        run(1);
        chk("t3_div_at_wrap", int'(ifc.div_active_o), 3);
        runs_clear();
        run(10);
        chk("t3_hi", last_hi, 2);
        chk("t3_lo", last_lo, 1);

        // Simultaneous load and wrap: old pending applies now, new one at the next wrap.
        step(1'b1, 1'b1, 4, 1'b1);
        run_to_cnt(2);
        step(1'b1, 1'b1, 5, 1'b1);
        chk("t3_sim_old_applied", int'(ifc.div_active_o), 4);
        run(4);
        chk("t3_sim_new_applied", int'(ifc.div_active_o), 5);

        // T4: clamp of 0 and 1, then max divisor.
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("t4_clamp0", int'(ifc.div_active_o), 2);
        step(1'b1, 1'b0, 1, 1'b1);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("t4_clamp1", int'(ifc.div_active_o), 2);
        runs_clear();
        run(8);
        chk("t4_n2_hi", last_hi, 1);
        chk("t4_n2_lo", last_lo, 1);
        step(1'b1, 1'b0, 255, 1'b1);
        runs_clear();
        run(520);
        chk("t4_max_div", int'(ifc.div_active_o), 255);
        chk("t4_max_hi", last_hi, 128);
        chk("t4_max_lo", last_lo, 127);

        // T5: stop mid high phase at N=7, then restart.
        step(1'b1, 1'b0, 7, 1'b1);
        run(3);
        run_to_cnt(2);
        step(1'b1, 1'b0, 0, 1'b0);
        chk("t5_stop_clk", int'(ifc.clk_o), 0);
        run(0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("t5_restart_clk", int'(ifc.clk_o), 1);
        chk("t5_restart_tick", int'(ifc.tick_o), 1);
        runs_clear();
        run(20);
        chk("t5_hi", last_hi, 4);
        chk("t5_lo", last_lo, 3);

        // T6: reset with a pending load of 9; it must never take effect.
        run_to_cnt(2);
        step(1'b1, 1'b1, 9, 1'b1);
        step(1'b0, 1'b1, 0, 1'b0);
        chk("t6_rst_clk", int'(ifc.clk_o), 0);
        chk("t6_rst_tick", int'(ifc.tick_o), 0);
        chk("t6_rst_div", int'(ifc.div_active_o), 2);
        runs_clear();
        run(20);
        chk("t6_div_after", int'(ifc.div_active_o), 2);
        chk("t6_hi", last_hi, 1);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
